// File: rtl/uart_rx_byte_receiver.sv
// 8N1 UART receiver: 2-flop synchronised serial line in, one byte per valid pulse out.
// Samples mid-bit from the start-edge reference and flags a low stop bit as a framing error.
module uart_rx_byte_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       data_from_pc_valid,
  output logic [7:0] data_from_pc,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m               <= 1'b1;
      rx_s               <= 1'b1;
      state              <= IDLE;
      baud_cnt           <= '0;
      bit_cnt            <= '0;
      data_from_pc_valid <= 1'b0;
      frame_error        <= 1'b0;
      data_from_pc       <= 8'h00;
    end else begin
      rx_m               <= uart_rx;
      rx_s               <= rx_m;
      state              <= state_nxt;
      baud_cnt           <= baud_cnt_nxt;
      bit_cnt            <= bit_cnt_nxt;
      data_from_pc_valid <= valid_nxt;
      frame_error        <= ferr_nxt;
      data_from_pc       <= data_nxt;
    end
  end

  // The shift register is pure datapath; its contents only matter once a full frame is in.
  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    data_nxt     = data_from_pc;
    valid_nxt    = 1'b0;
    ferr_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          state_nxt    = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {rx_s, shift_reg[7:1]};
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not re-trigger START, so wait for the line to recover.
        baud_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        baud_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
// Randomised scoreboard bench for uart_rx_byte_receiver at 16 clk per bit.
// Expected bytes/errors come from a frame-level model of mid-bit sample times.
module tb_uart_rx_byte_receiver;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       data_from_pc_valid;
  logic [7:0] data_from_pc;
  logic       frame_error;
  logic       rx_busy;

  uart_rx_byte_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk                (clk),
    .rst                (rst),
    .uart_rx            (uart_rx),
    .data_from_pc_valid (data_from_pc_valid),
    .data_from_pc       (data_from_pc),
    .frame_error        (frame_error),
    .rx_busy            (rx_busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         err_pend = 0;
  logic [7:0] last_good = 8'h00;
  int         last_valid_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Line level at time t (in half-cycles after the start edge) for one 8N1 frame of period p.
  function automatic logic line_at(input int t2, input int p, input logic [7:0] b,
                                   input logic stop, input logic after);
    int idx;
    idx = t2 / (2 * p);
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else if (idx == 9) return stop;
    else               return after;
  endfunction

  // The receiver looks at the line HALF_BIT+0.5+k*CLKS_PER_BIT cycles after a start edge
  // driven on a falling clock edge (k=0 start check, 1..8 data, 9 stop).
  task automatic predict(input logic [7:0] b, input int p, input logic stop, input logic after);
    logic [7:0] r;
    r = 8'h00;
    if (line_at(2*H + 1, p, b, stop, after)) return;
    for (int k = 1; k <= 8; k++) r[k-1] = line_at(2*H + 1 + 2*C*k, p, b, stop, after);
    if (line_at(2*H + 1 + 2*C*9, p, b, stop, after)) exp_q.push_back(r);
    else err_pend++;
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int p, input logic stop, input logic after);
    predict(b, p, stop, after);
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(b[i], p);
    hold(stop, p);
    uart_rx = after;
  endtask

  // Monitor: pops the scoreboard on every output pulse.
  initial forever begin
    @(negedge clk);
    if (data_from_pc_valid && frame_error) check("valid_and_ferr_together", 1, 0);
    if (data_from_pc_valid) begin
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_valid", int'(data_from_pc), -1);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rx_byte", int'(data_from_pc), int'(e));
        last_good = e;
      end
    end
    if (frame_error) begin
      check("ferr_expected", int'(err_pend > 0), 1);
      if (err_pend > 0) err_pend--;
      check("data_held_on_ferr", int'(data_from_pc), int'(last_good));
    end
  end

  initial begin
    int start_c, lat, busy_cnt, p;
    logic [7:0] b;
    logic st;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(data_from_pc_valid), 0);
    check("rst_ferr", int'(frame_error), 0);
    check("rst_data", int'(data_from_pc), 0);
    check("rst_busy", int'(rx_busy), 0);
    rst = 1'b0;
    hold(1'b1, 10);

    // Single ideal frame with latency measurement.
    start_c = cyc;
    send(8'hA5, C, 1'b1, 1'b1);
    hold(1'b1, 10);
    lat = last_valid_cyc - start_c;
    check("latency_155pm1", int'(lat >= 154 && lat <= 156), 1);
    check("idle_after_a5", int'(rx_busy), 0);

    // 19 back-to-back frames, no idle between them.
    for (int i = 0; i < 19; i++) send(8'(i), C, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("burst_all_delivered", exp_q.size(), 0);

    // 5-cycle glitch must be rejected at the start-bit mid-point.
    busy_cnt = 0;
    uart_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) uart_rx = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_window", int'(busy_cnt >= 6 && busy_cnt <= 12), 1);
    check("glitch_back_idle", int'(rx_busy), 0);

    // Stop bit low, line held low as a break, then recovery.
    send(8'h3C, C, 1'b0, 1'b0);
    hold(1'b0, 100);
    check("break_one_ferr", err_pend, 0);
    check("break_data_held", int'(data_from_pc), int'(last_good));
    hold(1'b1, 20);
    send(8'h7E, C, 1'b1, 1'b1);
    hold(1'b1, 10);

    // Reset during data bit 4 of 8'hFF discards the partial byte.
    hold(1'b0, C);
    hold(1'b1, 4*C + C/2);
    rst = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check("midrst_valid", int'(data_from_pc_valid), 0);
    check("midrst_ferr", int'(frame_error), 0);
    check("midrst_data", int'(data_from_pc), 0);
    check("midrst_busy", int'(rx_busy), 0);
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 20);
    send(8'h81, C, 1'b1, 1'b1);
    hold(1'b1, 20);

    // Off-nominal bit periods; outcome follows the sample-time model.
    send(8'h55, 15, 1'b1, 1'b1);
    hold(1'b1, 20);
    send(8'h55, 17, 1'b1, 1'b1);
    hold(1'b1, 20);

    // Random frames, periods 15..17, occasional bad stop bit.
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      p = int'($urandom_range(15, 17));
      st = (p == C) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      send(b, p, st, 1'b1);
      hold(1'b1, int'($urandom_range(12, 30)));
    end
    hold(1'b1, 20);

    check("no_missing_valid", exp_q.size(), 0);
    check("no_missing_ferr", err_pend, 0);
    check("final_idle", int'(rx_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
